// File: rtl/hashin_reader_if.sv
// Bus bundle between the hashin/nonce FIFO pair, the reader and the hash core.
// Ports (master = reader side):
//   hashin_fifo_out_dout/empty   FWFT head of the 64-bit hashin FIFO (in)
//   hashin_fifo_out_re           hashin FIFO pop (out)
//   nonce_fifo_dout/empty        FWFT head of the 32-bit nonce FIFO (in)
//   nonce_fifo_re                nonce FIFO pop (out)
//   hdr_out/hdr_nonce/hdr_valid  rebuilt header offered to the hash core (out)
//   hdr_ready                    hash core accepts (in)
interface hashin_reader_if #(
    parameter int unsigned HDR_WORDS = 10
);
    logic [63:0]             hashin_fifo_out_dout;
    logic                    hashin_fifo_out_empty;
    logic                    hashin_fifo_out_re;
    logic [31:0]             nonce_fifo_dout;
    logic                    nonce_fifo_empty;
    logic                    nonce_fifo_re;
    logic [HDR_WORDS*64-1:0] hdr_out;
    logic [31:0]             hdr_nonce;
    logic                    hdr_valid;
    logic                    hdr_ready;

    modport master (
        input  hashin_fifo_out_dout,
        input  hashin_fifo_out_empty,
        output hashin_fifo_out_re,
        input  nonce_fifo_dout,
        input  nonce_fifo_empty,
        output nonce_fifo_re,
        output hdr_out,
        output hdr_nonce,
        output hdr_valid,
        input  hdr_ready
    );

    modport slave (
        output hashin_fifo_out_dout,
        output hashin_fifo_out_empty,
        input  hashin_fifo_out_re,
        output nonce_fifo_dout,
        output nonce_fifo_empty,
        input  nonce_fifo_re,
        input  hdr_out,
        input  hdr_nonce,
        input  hdr_valid,
        output hdr_ready
    );
endinterface

// File: rtl/hashin_reader.sv
// Consumer of the hashin/nonce FIFO pair: pops a descriptor plus HDR_WORDS header words
// and the matching nonce, rebuilds the block header and offers it on a valid/ready port.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   stop              abort current frame and drain both FIFOs
//   stop_ack_reader   drain complete, held while stop=1
//   bus (master)      FIFO pop interfaces and header valid/ready port
//   desc_err          sticky: descriptor mismatch seen
//   nonce_err         sticky: header nonce field disagrees with the popped nonce
//   frame_cnt         frames delivered (wrapping)
module hashin_reader #(
    parameter int unsigned HDR_WORDS = 10,
    parameter logic [63:0] DESC_WORD = 64'h8000000000000280
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stop,
    output logic                   stop_ack_reader,
    hashin_reader_if.master        bus,
    output logic                   desc_err,
    output logic                   nonce_err,
    output logic [31:0]            frame_cnt
);
    localparam int unsigned HdrBits = HDR_WORDS * 64;
    localparam int unsigned CntW    = $clog2(HDR_WORDS + 1);

    typedef enum logic [2:0] {StDesc, StData, StNonce, StOut, StFlush} state_e;

    state_e              state_q, state_d;
    logic [CntW-1:0]     cnt_q;
    logic [HdrBits-1:0]  hdr_q;
    logic [31:0]         nonce_q;
    logic                desc_err_q, nonce_err_q, stop_ack_q;
    logic [31:0]         frame_cnt_q;

    logic                hashin_re, nonce_re, hdr_valid;
    logic                hashin_empty, nonce_empty;
    logic [63:0]         hashin_dout;
    logic [31:0]         nonce_dout, nonce_swapped;
    logic                handshake, enter_flush;

    assign hashin_empty  = bus.hashin_fifo_out_empty;
    assign hashin_dout   = bus.hashin_fifo_out_dout;
    assign nonce_empty   = bus.nonce_fifo_empty;
    assign nonce_dout    = bus.nonce_fifo_dout;
    // The header carries the nonce byte-reversed relative to the nonce FIFO word.
    assign nonce_swapped = {nonce_dout[7:0], nonce_dout[15:8], nonce_dout[23:16],
                            nonce_dout[31:24]};
    assign handshake     = hdr_valid & bus.hdr_ready;
    assign enter_flush   = stop && (state_q != StFlush);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StDesc;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; stop wins over every pop and handshake.
    always_comb begin
        state_d = state_q;
        if (enter_flush) begin
            state_d = StFlush;
        end else begin
            unique case (state_q)
                StDesc:  if (!hashin_empty && hashin_dout == DESC_WORD) state_d = StData;
                StData:  if (!hashin_empty && cnt_q == CntW'(HDR_WORDS - 1)) state_d = StNonce;
                StNonce: if (!nonce_empty) state_d = StOut;
                StOut:   if (bus.hdr_ready) state_d = StDesc;
                StFlush: if (!stop) state_d = StDesc;
                default: state_d = StDesc;
            endcase
        end
    end

    // Outputs: pops and valid are combinational from state, empty and stop.
    always_comb begin
        hashin_re = 1'b0;
        nonce_re  = 1'b0;
        hdr_valid = 1'b0;
        unique case (state_q)
            StDesc, StData: hashin_re = !stop && !hashin_empty;
            StNonce:        nonce_re  = !stop && !nonce_empty;
            StOut:          hdr_valid = !stop;
            StFlush: begin
                hashin_re = stop && !hashin_empty;
                nonce_re  = stop && !nonce_empty;
            end
            default: ;
        endcase
    end

    // Datapath, counters and sticky flags
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            hdr_q       <= '0;
            nonce_q     <= '0;
            desc_err_q  <= 1'b0;
            nonce_err_q <= 1'b0;
            stop_ack_q  <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_q + {31'd0, handshake};
            unique case (state_q)
                StDesc: begin
                    if (hashin_re) begin
                        if (hashin_dout == DESC_WORD) cnt_q <= '0;
                        else                          desc_err_q <= 1'b1;
                    end
                end
                StData: begin
                    if (hashin_re) begin
                        hdr_q <= {hdr_q[HdrBits-65:0], hashin_dout};
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StNonce: begin
                    if (nonce_re) begin
                        nonce_q <= nonce_dout;
                        if (hdr_q[31:0] != nonce_swapped) nonce_err_q <= 1'b1;
                    end
                end
                StFlush: begin
                    if (stop) begin
                        if (hashin_empty && nonce_empty) stop_ack_q <= 1'b1;
                    end else begin
                        stop_ack_q <= 1'b0;
                        cnt_q      <= '0;
                    end
                end
                default: ;
            endcase
            if (enter_flush) cnt_q <= '0;
        end
    end

    assign bus.hashin_fifo_out_re = hashin_re;
    assign bus.nonce_fifo_re      = nonce_re;
    assign bus.hdr_valid          = hdr_valid;
    assign bus.hdr_out            = hdr_q;
    assign bus.hdr_nonce          = nonce_q;
    assign stop_ack_reader        = stop_ack_q;
    assign desc_err               = desc_err_q;
    assign nonce_err              = nonce_err_q;
    assign frame_cnt              = frame_cnt_q;
endmodule

// File: tb/tb_hashin_reader.sv
module tb_hashin_reader;
    localparam logic [63:0] Desc = 64'h8000000000000280;

    logic        clk = 1'b0;
    logic        rst, stop, stop_ack;
    logic        desc_err, nonce_err;
    logic [31:0] frame_cnt;

    hashin_reader_if #(.HDR_WORDS(10)) bus ();

    hashin_reader #(.HDR_WORDS(10), .DESC_WORD(Desc)) dut (
        .clk             (clk),
        .rst             (rst),
        .stop            (stop),
        .stop_ack_reader (stop_ack),
        .bus             (bus),
        .desc_err        (desc_err),
        .nonce_err       (nonce_err),
        .frame_cnt       (frame_cnt)
    );

    always #5 clk = ~clk;

    // FWFT FIFO models
    logic [63:0] hmem [256];
    logic [31:0] nmem [64];
    int hwr = 0, hrd = 0, nwr = 0, nrd = 0;
    int bad_pop = 0;

    assign bus.hashin_fifo_out_dout  = hmem[hrd[7:0]];
    assign bus.hashin_fifo_out_empty = (hwr == hrd);
    assign bus.nonce_fifo_dout       = nmem[nrd[5:0]];
    assign bus.nonce_fifo_empty      = (nwr == nrd);

    always @(posedge clk) begin
        if (bus.hashin_fifo_out_re) begin
            if (hwr == hrd) bad_pop <= bad_pop + 1;
            else            hrd <= hrd + 1;
        end
        if (bus.nonce_fifo_re) begin
            if (nwr == nrd) bad_pop <= bad_pop + 1;
            else            nrd <= nrd + 1;
        end
    end

    int checks = 0, errors = 0;
    logic [63:0]  words [10];
    logic [639:0] exp_hdr;

    task automatic check(input string tag, input logic [639:0] obs, input logic [639:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_w(input logic [63:0] w);
        hmem[hwr[7:0]] = w;
        hwr = hwr + 1;
    endtask

    task automatic push_n(input logic [31:0] n);
        nmem[nwr[5:0]] = n;
        nwr = nwr + 1;
    endtask

    function automatic logic [31:0] bswap(input logic [31:0] n);
        return {n[7:0], n[15:8], n[23:16], n[31:24]};
    endfunction

    // Build ten header words; the last one carries hdr_field in its low 32 bits.
    task automatic make_frame(input logic [63:0] seed, input logic [31:0] hdr_field);
        exp_hdr = '0;
        for (int i = 0; i < 10; i++) begin
            if (i < 9) words[i] = seed + 64'h0101_0101_0000_0001 * 64'(i);
            else       words[i] = {seed[63:32] ^ 32'hFFFF_0000, hdr_field};
            exp_hdr = {exp_hdr[575:0], words[i]};
        end
    endtask

    task automatic push_words(input int from, input int to);
        for (int i = from; i <= to; i++) push_w(words[i]);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_valid(input string tag, output int n);
        n = 0;
        while (!bus.hdr_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({tag, " valid"}, 640'(bus.hdr_valid), 640'(1));
    endtask

    task automatic handshake();
        bus.hdr_ready = 1'b1;
        @(negedge clk);
        bus.hdr_ready = 1'b0;
    endtask

    int   n, h0;
    logic saw_valid;

    initial begin
        rst = 1'b1;
        stop = 1'b0;
        bus.hdr_ready = 1'b0;
        tick(3);
        check("rst valid", 640'(bus.hdr_valid), 640'(0));
        check("rst hdr", bus.hdr_out, 640'(0));
        check("rst nonce", 640'(bus.hdr_nonce), 640'(0));
        check("rst errs", 640'({desc_err, nonce_err, stop_ack}), 640'(0));
        check("rst cnt", 640'(frame_cnt), 640'(0));
        rst = 1'b0;
        tick(1);

        // 1) single frame, latency 12 cycles from preload to valid
        make_frame(64'h1111_2222_0000_0000, 32'h78563412);
        push_w(Desc);
        push_words(0, 9);
        push_n(32'h12345678);
        wait_valid("t1", n);
        check("t1 latency", 640'(n), 640'(12));
        check("t1 hdr", bus.hdr_out, exp_hdr);
        check("t1 nonce", 640'(bus.hdr_nonce), 640'(32'h12345678));
        check("t1 errs", 640'({desc_err, nonce_err}), 640'(0));
        handshake();
        check("t1 cnt", 640'(frame_cnt), 640'(1));
        check("t1 valid drop", 640'(bus.hdr_valid), 640'(0));

        // 2) backpressure; a garbage word is queued behind the frame for test 3
        make_frame(64'h3333_4444_5555_0000, bswap(32'hCAFE0001));
        push_w(Desc);
        push_words(0, 9);
        push_n(32'hCAFE0001);
        push_w(64'h0);
        wait_valid("t2", n);
        h0 = hrd;
        tick(5);
        check("t2 held valid", 640'(bus.hdr_valid), 640'(1));
        check("t2 hdr stable", bus.hdr_out, exp_hdr);
        check("t2 nonce", 640'(bus.hdr_nonce), 640'(32'hCAFE0001));
        check("t2 no pops", 640'(hrd - h0), 640'(0));
        check("t2 re low", 640'({bus.hashin_fifo_out_re, bus.nonce_fifo_re}), 640'(0));
        handshake();
        check("t2 cnt", 640'(frame_cnt), 640'(2));
        check("t2 next pop", 640'(bus.hashin_fifo_out_re), 640'(1));
        check("t2 valid drop", 640'(bus.hdr_valid), 640'(0));

        // 3) garbage word dropped, following frame delivered
        make_frame(64'h0BAD_0000_1234_5678, bswap(32'h0BADF00D));
        push_w(Desc);
        push_words(0, 9);
        push_n(32'h0BADF00D);
        wait_valid("t3", n);
        check("t3 desc_err", 640'(desc_err), 640'(1));
        check("t3 nonce_err", 640'(nonce_err), 640'(0));
        check("t3 hdr", bus.hdr_out, exp_hdr);
        handshake();
        check("t3 cnt", 640'(frame_cnt), 640'(3));

        // 4) header encodes nonce 2, FIFO holds 1
        make_frame(64'h4444_0000_9999_0000, bswap(32'h00000002));
        push_w(Desc);
        push_words(0, 9);
        push_n(32'h00000001);
        wait_valid("t4", n);
        check("t4 nonce_err", 640'(nonce_err), 640'(1));
        check("t4 nonce", 640'(bus.hdr_nonce), 640'(1));
        check("t4 hdr", bus.hdr_out, exp_hdr);
        handshake();
        check("t4 cnt", 640'(frame_cnt), 640'(4));

        // 5) stop after four data words
        make_frame(64'h5555_0000_0000_0000, bswap(32'd77));
        push_w(Desc);
        push_words(0, 9);
        push_n(32'd77);
        tick(5);
        check("t5 queued hashin", 640'(hwr - hrd), 640'(6));
        check("t5 queued nonce", 640'(nwr - nrd), 640'(1));
        stop = 1'b1;
        saw_valid = 1'b0;
        n = 0;
        while (!stop_ack && n < 30) begin
            @(negedge clk);
            saw_valid |= bus.hdr_valid;
            n++;
        end
        check("t5 stop_ack", 640'(stop_ack), 640'(1));
        check("t5 no valid", 640'(saw_valid), 640'(0));
        check("t5 drained", 640'({hwr - hrd, nwr - nrd}), 640'(0));
        tick(2);
        check("t5 ack held", 640'(stop_ack), 640'(1));
        stop = 1'b0;
        tick(1);
        check("t5 ack clear", 640'(stop_ack), 640'(0));

        // 6) frame_cnt wrap, with empty-FIFO stalls mid-DATA
        force dut.frame_cnt_q = 32'hFFFF_FFFF;
        tick(2);
        release dut.frame_cnt_q;
        tick(1);
        check("t6 preload", 640'(frame_cnt), 640'(32'hFFFF_FFFF));
        make_frame(64'h6666_7777_8888_9999, bswap(32'h55AA33CC));
        push_w(Desc);
        push_words(0, 2);
        tick(6);
        check("t6 stall valid", 640'(bus.hdr_valid), 640'(0));
        push_words(3, 9);
        push_n(32'h55AA33CC);
        wait_valid("t6", n);
        check("t6 hdr", bus.hdr_out, exp_hdr);
        check("t6 nonce", 640'(bus.hdr_nonce), 640'(32'h55AA33CC));
        handshake();
        check("t6 cnt wrap", 640'(frame_cnt), 640'(0));
        check("t6 sticky", 640'({desc_err, nonce_err}), 640'(2'b11));

        // 7) reset mid-frame clears everything
        make_frame(64'h7777_0000_0000_0000, bswap(32'd5));
        push_w(Desc);
        push_words(0, 2);
        tick(3);
        rst = 1'b1;
        tick(1);
        check("t7 hdr", bus.hdr_out, 640'(0));
        check("t7 flags", 640'({bus.hdr_valid, desc_err, nonce_err, stop_ack}), 640'(0));
        check("t7 cnt", 640'(frame_cnt), 640'(0));
        rst = 1'b0;
        tick(1);

        check("pop on empty", 640'(bad_pop), 640'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
